// File: rtl/uart_rx_frame_ctrl_if.sv
// Payload stream from the frame controller to the command decoder.
// Valid/ready handshake, with last-byte and frame-length qualifiers.
interface uart_rx_frame_ctrl_if;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_ready;
    logic       pkt_last;
    logic [7:0] pkt_len;

    modport master (
        output pkt_data,
        output pkt_valid,
        output pkt_last,
        output pkt_len,
        input  pkt_ready
    );

    modport slave (
        input  pkt_data,
        input  pkt_valid,
        input  pkt_last,
        input  pkt_len,
        output pkt_ready
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the oversampling UART receiver: sync hunt,
// LEN/payload/checksum parsing, gap timeout, buffered payload drain.
module uart_rx_frame_ctrl #(
    parameter int unsigned MAX_LEN       = 16,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int unsigned TIMEOUT_TICKS = 320
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic [7:0]                  rx_byte,
    input  logic                        rx_byte_valid,
    uart_rx_frame_ctrl_if.master        pkt,
    output logic                        frame_ok,
    output logic                        err_chk,
    output logic                        err_len,
    output logic                        err_timeout,
    output logic                        err_overrun,
    output logic                        busy
);

    localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned GW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [7:0]    MAXL  = 8'(MAX_LEN);
    localparam logic [GW-1:0] GLAST = GW'(TIMEOUT_TICKS - 1);
    localparam logic [GW-1:0] GONE  = GW'(1);

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, DRAIN} state_t;

    state_t        state, state_n;
    logic [7:0]    len, len_n;
    logic [7:0]    sum, sum_n;
    logic [7:0]    idx, idx_n;
    logic [GW-1:0] gap, gap_n;
    logic [7:0]    mem [2**IW];

    logic wr_en, last, timed, tmo;
    logic ok_n, chk_n, lenerr_n, to_n, ov_n;

    assign last  = (idx == len - 8'd1);
    assign timed = (state == LEN) || (state == PAYLOAD) || (state == CHK);
    // A byte arriving on the terminal tick beats the timeout.
    assign tmo   = timed && tick && (gap == GLAST) && !rx_byte_valid;

    always_comb begin
        state_n  = state;
        len_n    = len;
        sum_n    = sum;
        idx_n    = idx;
        gap_n    = gap;
        wr_en    = 1'b0;
        ok_n     = 1'b0;
        chk_n    = 1'b0;
        lenerr_n = 1'b0;
        to_n     = 1'b0;
        ov_n     = 1'b0;
        if (timed && tick)
            gap_n = gap + GONE;
        unique case (state)
            IDLE: begin
                if (rx_byte_valid && rx_byte == SYNC_BYTE) begin
                    state_n = LEN;
                    gap_n   = '0;
                end
            end
            LEN: begin
                if (rx_byte_valid) begin
                    gap_n = '0;
                    if (rx_byte != 8'd0 && rx_byte <= MAXL) begin
                        len_n   = rx_byte;
                        sum_n   = rx_byte;
                        idx_n   = 8'd0;
                        state_n = PAYLOAD;
                    end else begin
                        lenerr_n = 1'b1;
                        state_n  = IDLE;
                    end
                end else if (tmo) begin
                    to_n    = 1'b1;
                    state_n = IDLE;
                end
            end
            PAYLOAD: begin
                if (rx_byte_valid) begin
                    gap_n = '0;
                    wr_en = 1'b1;
                    sum_n = sum + rx_byte;
                    idx_n = idx + 8'd1;
                    if (last)
                        state_n = CHK;
                end else if (tmo) begin
                    to_n    = 1'b1;
                    state_n = IDLE;
                end
            end
            CHK: begin
                if (rx_byte_valid) begin
                    gap_n = '0;
                    if (8'(sum + rx_byte) == 8'h00) begin
                        ok_n    = 1'b1;
                        idx_n   = 8'd0;
                        state_n = DRAIN;
                    end else begin
                        chk_n   = 1'b1;
                        state_n = IDLE;
                    end
                end else if (tmo) begin
                    to_n    = 1'b1;
                    state_n = IDLE;
                end
            end
            DRAIN: begin
                if (rx_byte_valid)
                    ov_n = 1'b1;
                if (pkt.pkt_ready) begin
                    idx_n = idx + 8'd1;
                    if (last)
                        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            len         <= 8'd0;
            sum         <= 8'd0;
            idx         <= 8'd0;
            gap         <= '0;
            frame_ok    <= 1'b0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_n;
            len         <= len_n;
            sum         <= sum_n;
            idx         <= idx_n;
            gap         <= gap_n;
            frame_ok    <= ok_n;
            err_chk     <= chk_n;
            err_len     <= lenerr_n;
            err_timeout <= to_n;
            err_overrun <= ov_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[idx[IW-1:0]] <= rx_byte;
    end

    assign busy          = (state != IDLE);
    assign pkt.pkt_valid = (state == DRAIN);
    assign pkt.pkt_data  = (state == DRAIN) ? mem[idx[IW-1:0]] : 8'h00;
    assign pkt.pkt_last  = (state == DRAIN) && last;
    assign pkt.pkt_len   = len;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: frame table plus sequences
// for timeout, backpressure/overrun and mid-frame reset.
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       frame_ok, err_chk, err_len, err_timeout, err_overrun, busy;

    uart_rx_frame_ctrl_if pif ();

    uart_rx_frame_ctrl #(
        .MAX_LEN       (16),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_TICKS (320)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .pkt           (pif.master),
        .frame_ok      (frame_ok),
        .err_chk       (err_chk),
        .err_len       (err_len),
        .err_timeout   (err_timeout),
        .err_overrun   (err_overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0][7:0] b;
        int               n;
        int               off;
        int               e_ok;
        int               e_chk;
        int               e_len;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic [7:0] ln;
        int         c;
    } beat_t;

    vec_t  tv [8];
    beat_t beats [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, ok_cyc = 0;
    int n_ok, n_chk, n_len, n_to, n_ov, n_val;

    always @(negedge clk) begin
        cyc++;
        if (frame_ok)    begin n_ok++; ok_cyc = cyc; end
        if (err_chk)     n_chk++;
        if (err_len)     n_len++;
        if (err_timeout) n_to++;
        if (err_overrun) n_ov++;
        if (pif.pkt_valid) n_val++;
        if (pif.pkt_valid && pif.pkt_ready)
            beats.push_back('{pif.pkt_data, pif.pkt_last, pif.pkt_len, cyc});
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        n_ok = 0; n_chk = 0; n_len = 0; n_to = 0; n_ov = 0; n_val = 0;
        beats.delete();
    endtask

    task automatic send_byte(input logic [7:0] v);
        @(posedge clk); #1;
        rx_byte       = v;
        rx_byte_valid = 1'b1;
        @(posedge clk); #1;
        rx_byte_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 tick = 1'b1;
            @(posedge clk); #1 tick = 1'b0;
        end
    endtask

    task automatic check_payload(input string nm, input logic [7:0] p [],
                                 input bit timing);
        check({nm, " beats"}, beats.size(), p.size());
        if (beats.size() == p.size())
            for (int k = 0; k < p.size(); k++) begin
                check({nm, " data"}, beats[k].d, p[k]);
                check({nm, " last"}, beats[k].l, (k == p.size() - 1));
                check({nm, " len"}, beats[k].ln, p.size());
                if (timing)
                    check({nm, " cycle"}, beats[k].c, ok_cyc + k);
            end
    endtask

    task automatic idle_outputs(input string nm);
        check({nm, " outs"},
              {pif.pkt_valid, pif.pkt_last, frame_ok, err_chk, err_len,
               err_timeout, err_overrun, busy}, 0);
        check({nm, " data"}, pif.pkt_data, 0);
        check({nm, " plen"}, pif.pkt_len, 0);
    endtask

    initial begin
        logic [7:0] exp_p [];
        int         L;
        bit         stable;

        tv[0] = '{b: '0, n: 6, off: 1, e_ok: 1, e_chk: 0, e_len: 0};
        {tv[0].b[0], tv[0].b[1], tv[0].b[2], tv[0].b[3], tv[0].b[4],
         tv[0].b[5]} = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        tv[1] = '{b: '0, n: 5, off: 1, e_ok: 0, e_chk: 1, e_len: 0};
        {tv[1].b[0], tv[1].b[1], tv[1].b[2], tv[1].b[3], tv[1].b[4]} =
            {8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        tv[2] = '{b: '0, n: 2, off: 1, e_ok: 0, e_chk: 0, e_len: 1};
        {tv[2].b[0], tv[2].b[1]} = {8'hA5, 8'h00};
        tv[3] = '{b: '0, n: 2, off: 1, e_ok: 0, e_chk: 0, e_len: 1};
        {tv[3].b[0], tv[3].b[1]} = {8'hA5, 8'h11};
        tv[4] = '{b: '0, n: 4, off: 1, e_ok: 1, e_chk: 0, e_len: 0};
        {tv[4].b[0], tv[4].b[1], tv[4].b[2], tv[4].b[3]} =
            {8'hA5, 8'h01, 8'h7F, 8'h80};
        tv[5] = '{b: '0, n: 5, off: 2, e_ok: 1, e_chk: 0, e_len: 0};
        {tv[5].b[0], tv[5].b[1], tv[5].b[2], tv[5].b[3], tv[5].b[4]} =
            {8'h3C, 8'hA5, 8'h01, 8'hFF, 8'h00};
        tv[6] = '{b: '0, n: 2, off: 1, e_ok: 0, e_chk: 0, e_len: 1};
        {tv[6].b[0], tv[6].b[1]} = {8'hA5, 8'hA5};
        // Max-length frame: payload 00..0F, LEN+sum = 0x88, CHK = 0x78.
        tv[7] = '{b: '0, n: 19, off: 1, e_ok: 1, e_chk: 0, e_len: 0};
        tv[7].b[0] = 8'hA5;
        tv[7].b[1] = 8'h10;
        for (int k = 0; k < 16; k++) tv[7].b[2+k] = 8'(k);
        tv[7].b[18] = 8'h78;

        reset = 1'b1; tick = 1'b0; rx_byte = 8'h00; rx_byte_valid = 1'b0;
        pif.pkt_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        idle_outputs("reset");
        @(posedge clk); #1 reset = 1'b0;
        clear_mon();

        for (int i = 0; i < 8; i++) begin
            clear_mon();
            for (int k = 0; k < tv[i].n; k++) send_byte(tv[i].b[k]);
            repeat (25) @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d ok", i), n_ok, tv[i].e_ok);
            check($sformatf("v%0d chk", i), n_chk, tv[i].e_chk);
            check($sformatf("v%0d len", i), n_len, tv[i].e_len);
            check($sformatf("v%0d to/ov", i), n_to + n_ov, 0);
            check($sformatf("v%0d busy", i), busy, 0);
            L = (tv[i].e_ok != 0) ? int'(tv[i].b[tv[i].off]) : 0;
            exp_p = new[L];
            for (int k = 0; k < L; k++) exp_p[k] = tv[i].b[tv[i].off+1+k];
            if (tv[i].e_ok == 0)
                check($sformatf("v%0d novalid", i), n_val, 0);
            check_payload($sformatf("v%0d", i), exp_p, 1'b1);
        end

        // Gap timeout fires on the 320th tick after the last byte.
        clear_mon();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h55);
        ticks(319);
        @(negedge clk);
        check("to early", n_to, 0);
        check("to busy pre", busy, 1);
        ticks(1);
        repeat (3) @(negedge clk);
        check("to fired", n_to, 1);
        check("to busy post", busy, 0);
        check("to others", n_ok + n_chk + n_len + n_ov, 0);

        // Byte landing on the terminal tick wins.
        clear_mon();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h55);
        ticks(319);
        @(posedge clk); #1;
        tick = 1'b1; rx_byte = 8'h66; rx_byte_valid = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0; rx_byte_valid = 1'b0;
        send_byte(8'h43);
        repeat (10) @(negedge clk);
        check("race to", n_to, 0);
        check("race ok", n_ok, 1);
        exp_p = new[2];
        exp_p[0] = 8'h55; exp_p[1] = 8'h66;
        check_payload("race", exp_p, 1'b1);

        // Backpressure with an overrun byte mid-drain.
        clear_mon();
        pif.pkt_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
        send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hF2);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            rx_byte = 8'h5A;
            rx_byte_valid = (i == 4);
            @(negedge clk);
            if (!(pif.pkt_valid && pif.pkt_data == 8'h01 &&
                  !pif.pkt_last && pif.pkt_len == 8'd4))
                stable = 1'b0;
        end
        check("bp stable", stable, 1);
        check("bp overrun", n_ov, 1);
        @(posedge clk); #1 pif.pkt_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("bp ok", n_ok, 1);
        check("bp busy", busy, 0);
        exp_p = new[4];
        exp_p[0] = 8'h01; exp_p[1] = 8'h02; exp_p[2] = 8'h03; exp_p[3] = 8'h04;
        check_payload("bp", exp_p, 1'b0);

        // Reset mid-payload aborts silently.
        clear_mon();
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        idle_outputs("midrst");
        check("midrst err", n_chk + n_len + n_to + n_ov + n_ok, 0);
        clear_mon();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
        send_byte(8'hBB); send_byte(8'h99);
        repeat (10) @(negedge clk);
        check("post ok", n_ok, 1);
        exp_p = new[2];
        exp_p[0] = 8'hAA; exp_p[1] = 8'hBB;
        check_payload("post", exp_p, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
